// File: rtl/move_pkg.sv
// Shared types and constants for the tic-tac-toe move entry block.
package move_pkg;

  localparam logic [3:0] MOVE_NONE = 4'hF;

  typedef logic [3:0] square_t;
  typedef logic [8:0] board_t;

  typedef enum logic [1:0] {
    WAIT_H = 2'b00,
    WAIT_C = 2'b01,
    DONE   = 2'b10
  } state_t;

  // One-hot board bit for a square number; zero for anything outside 1..9.
  function automatic board_t sq_mask(input square_t sq);
    board_t m;
    m = '0;
    if (sq >= 4'd1 && sq <= 4'd9)
      m = board_t'(9'd1 << (sq - 4'd1));
    return m;
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Pushbutton conditioner: 2-flop synchronizer, optional debounce
// (MOVE_ENTRY_DEBOUNCE_EN), rising-edge detector producing a one-cycle press.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset_L,
  input  logic raw,
  output logic press
);

  if (DEBOUNCE_CYCLES < 1) begin : g_cfg_check
    $error("btn_conditioner: DEBOUNCE_CYCLES must be at least 1");
  end

  logic raw_p0, raw_p1;
  logic level;
  logic level_p2;

  // stage p0/p1: metastability synchronizer
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      raw_p0 <= 1'b0;
      raw_p1 <= 1'b0;
    end else begin
      raw_p0 <= raw;
      raw_p1 <= raw_p0;
    end
  end

`ifdef MOVE_ENTRY_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] stable_cnt;
  logic             deb_level;

  // level flips only after DEBOUNCE_CYCLES consecutive samples disagreeing with it
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      stable_cnt <= '0;
      deb_level  <= 1'b0;
    end else if (raw_p1 == deb_level) begin
      stable_cnt <= '0;
    end else if (stable_cnt == CNT_LAST) begin
      stable_cnt <= '0;
      deb_level  <= raw_p1;
    end else begin
      stable_cnt <= stable_cnt + 1'b1;
    end
  end

  assign level = deb_level;
`else
  assign level = raw_p1;
`endif

  // stage p2: edge register
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L)
      level_p2 <= 1'b0;
    else
      level_p2 <= level;
  end

  assign press = level & ~level_p2;

endmodule

// File: rtl/move_entry.sv
// Human move entry for tic-tac-toe: validates button presses against the
// board, tracks computer moves and game over. Optional debounce via
// MOVE_ENTRY_DEBOUNCE_EN.
module move_entry
  import move_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset_L,
  input  logic [3:0] sw,
  input  logic       enter,
  input  logic [3:0] cMove,
  input  logic       win,
  input  logic       newGame,
  output logic [3:0] hMove,
  output logic       moveErr,
  output logic [8:0] board,
  output logic [1:0] state
);

  square_t sw_p0, sw_p1;
  logic    press;

  state_t  st, st_n;
  board_t  board_q, board_n;
  square_t hmove_q, hmove_n;
  logic    err_q, err_n;

  board_t  sw_mask, cm_mask;
  logic    sw_legal, cm_legal, game_over;

  // stage p0/p1: square-select synchronizer
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      sw_p0 <= '0;
      sw_p1 <= '0;
    end else begin
      sw_p0 <= sw;
      sw_p1 <= sw_p0;
    end
  end

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_enter (
    .clock  (clock),
    .reset_L(reset_L),
    .raw    (enter),
    .press  (press)
  );

  assign sw_mask   = sq_mask(sw_p1);
  assign cm_mask   = sq_mask(cMove);
  assign sw_legal  = (sw_mask != '0) && ((sw_mask & board_q) == '0);
  assign cm_legal  = (cm_mask != '0) && ((cm_mask & board_q) == '0);
  assign game_over = win | (&board_q);

  // stage p3: game state, board and registered outputs
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      st      <= WAIT_H;
      board_q <= '0;
      hmove_q <= MOVE_NONE;
      err_q   <= 1'b0;
    end else begin
      st      <= st_n;
      board_q <= board_n;
      hmove_q <= hmove_n;
      err_q   <= err_n;
    end
  end

  always_comb begin
    st_n    = st;
    board_n = board_q;
    hmove_n = MOVE_NONE;
    err_n   = 1'b0;
    if (newGame) begin
      board_n = '0;
      st_n    = WAIT_H;
    end else if (game_over) begin
      st_n  = DONE;
      err_n = press;
    end else begin
      unique case (st)
        WAIT_H: begin
          // a press takes priority; computer moves are not accepted here
          if (press) begin
            if (sw_legal) begin
              hmove_n = sw_p1;
              board_n = board_q | sw_mask;
              st_n    = WAIT_C;
            end else begin
              err_n = 1'b1;
            end
          end
        end
        WAIT_C: begin
          err_n = press;
          if (cm_legal) begin
            board_n = board_q | cm_mask;
            st_n    = WAIT_H;
          end
        end
        DONE: begin
          err_n = press;
        end
        default: begin
          st_n = WAIT_H;
        end
      endcase
    end
  end

  assign hMove   = hmove_q;
  assign moveErr = err_q;
  assign board   = board_q;
  assign state   = st;

endmodule

// File: tb/tb_move_entry.sv
// Directed self-checking bench for move_entry; latency adapts to
// MOVE_ENTRY_DEBOUNCE_EN.
module tb_move_entry;

`ifdef MOVE_ENTRY_DEBOUNCE_EN
  localparam int LAT = 19;
  localparam int GAP = 20;
`else
  localparam int LAT = 3;
  localparam int GAP = 4;
`endif

  logic       clock = 1'b0;
  logic       reset_L;
  logic [3:0] sw;
  logic       enter;
  logic [3:0] cMove;
  logic       win;
  logic       newGame;
  logic [3:0] hMove;
  logic       moveErr;
  logic [8:0] board;
  logic [1:0] state;

  int checks = 0;
  int failures = 0;

  move_entry #(.DEBOUNCE_CYCLES(16)) dut (
    .clock  (clock),
    .reset_L(reset_L),
    .sw     (sw),
    .enter  (enter),
    .cMove  (cMove),
    .win    (win),
    .newGame(newGame),
    .hMove  (hMove),
    .moveErr(moveErr),
    .board  (board),
    .state  (state)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Press sw=s and check the one-cycle response at the expected latency.
  task automatic press_chk(input string tag, input logic [3:0] s,
                           input logic [3:0] eh, input logic ee);
    sw = s;
    enter = 1'b1;
    repeat (LAT - 1) tick();
    check({tag, "_pre"}, 16'(hMove), 16'hF);
    tick();
    check({tag, "_h"}, 16'(hMove), 16'(eh));
    check({tag, "_err"}, 16'(moveErr), 16'(ee));
    tick();
    check({tag, "_hpost"}, 16'(hMove), 16'hF);
    check({tag, "_errpost"}, 16'(moveErr), 16'h0);
    enter = 1'b0;
    repeat (GAP) tick();
  endtask

  initial begin
    int cnt;
    reset_L = 1'b0;
    sw = 4'd0;
    enter = 1'b0;
    cMove = 4'd0;
    win = 1'b0;
    newGame = 1'b0;
    repeat (2) tick();
    check("rst_h", 16'(hMove), 16'hF);
    check("rst_err", 16'(moveErr), 16'h0);
    check("rst_board", 16'(board), 16'h0);
    check("rst_state", 16'(state), 16'h0);
    reset_L = 1'b1;
    repeat (2) tick();

    // first human move on square 6
    press_chk("mv6", 4'd6, 4'd6, 1'b0);
    check("mv6_board", 16'(board), 16'h020);
    check("mv6_state", 16'(state), 16'h1);

    // computer: taken and out-of-range squares ignored, then square 9
    cMove = 4'd6;
    tick();
    check("cm_taken_board", 16'(board), 16'h020);
    check("cm_taken_state", 16'(state), 16'h1);
    cMove = 4'd12;
    tick();
    check("cm_range_state", 16'(state), 16'h1);
    cMove = 4'd9;
    tick();
    cMove = 4'd0;
    check("cm9_board", 16'(board), 16'h120);
    check("cm9_state", 16'(state), 16'h0);

    // illegal presses
    press_chk("taken6", 4'd6, 4'hF, 1'b1);
    press_chk("sw0", 4'd0, 4'hF, 1'b1);
    press_chk("sw12", 4'd12, 4'hF, 1'b1);
    check("illegal_board", 16'(board), 16'h120);
    check("illegal_state", 16'(state), 16'h0);

    // held enter gives exactly one move
    sw = 4'd3;
    enter = 1'b1;
    cnt = 0;
    repeat (20) begin
      tick();
      if (hMove == 4'd3) cnt++;
    end
    enter = 1'b0;
    repeat (LAT + GAP) begin
      tick();
      if (hMove == 4'd3) cnt++;
    end
    check("hold_count", 16'(cnt), 16'd1);
    check("hold_board", 16'(board), 16'h124);
    check("hold_state", 16'(state), 16'h1);

    // press while waiting for the computer
    press_chk("waitc", 4'd4, 4'hF, 1'b1);
    check("waitc_board", 16'(board), 16'h124);
    cMove = 4'd1;
    tick();
    cMove = 4'd0;
    check("cm1_board", 16'(board), 16'h125);
    check("cm1_state", 16'(state), 16'h0);

    // win -> DONE, presses rejected
    win = 1'b1;
    tick();
    win = 1'b0;
    check("win_state", 16'(state), 16'h2);
    press_chk("done", 4'd8, 4'hF, 1'b1);
    check("done_state", 16'(state), 16'h2);

    // newGame coincident with a press
    sw = 4'd5;
    enter = 1'b1;
    repeat (LAT - 1) tick();
    newGame = 1'b1;
    tick();
    newGame = 1'b0;
    check("ng_h", 16'(hMove), 16'hF);
    check("ng_err", 16'(moveErr), 16'h0);
    check("ng_board", 16'(board), 16'h0);
    check("ng_state", 16'(state), 16'h0);
    tick();
    check("ng_h2", 16'(hMove), 16'hF);
    enter = 1'b0;
    repeat (GAP) tick();

    // press wins over a simultaneous computer move in WAIT_H
    sw = 4'd5;
    cMove = 4'd2;
    enter = 1'b1;
    repeat (LAT) tick();
    check("pc_h", 16'(hMove), 16'd5);
    check("pc_board", 16'(board), 16'h010);
    cMove = 4'd0;
    tick();
    check("pc_state", 16'(state), 16'h1);
    enter = 1'b0;
    repeat (GAP) tick();
    cMove = 4'd2;
    tick();
    cMove = 4'd0;
    check("cm2_board", 16'(board), 16'h012);

    // reset during the hMove cycle
    sw = 4'd7;
    enter = 1'b1;
    repeat (LAT) tick();
    check("mid_h", 16'(hMove), 16'd7);
    #1 reset_L = 1'b0;
    sw = 4'd5;
    #1;
    check("arst_h", 16'(hMove), 16'hF);
    check("arst_board", 16'(board), 16'h0);
    check("arst_state", 16'(state), 16'h0);
    tick();
    reset_L = 1'b1;
    repeat (LAT - 1) tick();
    check("post_pre", 16'(hMove), 16'hF);
    tick();
    check("post_h", 16'(hMove), 16'd5);
    tick();
    check("post_board", 16'(board), 16'h010);
    check("post_state", 16'(state), 16'h1);
    enter = 1'b0;
    repeat (GAP) tick();

`ifdef MOVE_ENTRY_DEBOUNCE_EN
    // short glitch must not register as a press
    enter = 1'b1;
    repeat (10) tick();
    enter = 1'b0;
    cnt = 0;
    repeat (40) begin
      tick();
      if (hMove != 4'hF || moveErr) cnt++;
    end
    check("glitch_events", 16'(cnt), 16'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
